lut_cfg_array: RTL
==================

# lut_cfg_array

Array of N independent, runtime-reprogrammable K-input look-up tables with registered outputs. Each channel reads one bit from its own 2^K-entry table. The tables reset to a fixed default function. They are reloaded serially through a configuration port while evaluation continues from the old contents. The block is the general form of the fixed 3-input LUT used in the multiplier datapath, and it serves as the programmable partial-product / control-decode element.

## Interface
- K, 3, LUT inputs per channel (1..6)
- N, 1, number of channels
- INIT, {N{8'h45}}, reset table contents, N*2^K bits; channel c owns bits [c*2^K +: 2^K]. 8'h45 encodes F = !C && (!A || B) with address {A,B,C}.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  evaluate `din` this cycle
- din  in  N*K  channel c address = din[c*K +: K]
- out_valid  out  1  `dout` holds a fresh result
- dout  out  N  registered LUT outputs, bit c = channel c
- cfg_start  in  1  begin (or restart) a configuration load
- cfg_valid  in  1  `cfg_bit` is valid this cycle
- cfg_bit  in  1  serial configuration data
- cfg_ready  out  1  high in LOAD; a bit is accepted when cfg_valid && cfg_ready
- cfg_done  out  1  one-cycle pulse when the new table becomes active

## Operation
- **Tables.** Active table `tbl` (TBL = N*2^K bits) plus shadow register `shd` of the same width. Evaluation reads only `tbl`.
- **Evaluation.** When in_valid is high, dout[c] <= tbl[c*2^K + din[c*K +: K]] and out_valid <= 1. When in_valid is low, out_valid <= 0 and dout holds its value.
- **FSM states.**
  - IDLE: cfg_start -> LOAD; counter cleared; shd <= tbl.
  - LOAD: each accepted bit does shd <= {cfg_bit, shd[TBL-1:1]} and counter+1. When the counter reaches TBL-1 on an accepted bit -> COMMIT.
  - COMMIT: tbl <= shd; cfg_done = 1 -> IDLE.
- **Bit order.** Bits are sent LSB-first. The first bit sent ends up in tbl[0] (channel 0, address 0). The last bit sent ends up in tbl[TBL-1].
- **Counter.** Width is clog2(TBL). It never wraps; the exit to COMMIT happens at exactly TBL accepted bits.
- **cfg_start in LOAD.** Aborts the load and restarts it: counter cleared, shd <= tbl. No bit is accepted that cycle.
- **cfg_start in COMMIT.** Ignored.
- **cfg_valid outside LOAD.** Ignored.
- **Reset.** Asserting rst_n low at any time, including mid-load, gives: tbl = INIT, shd = INIT, state IDLE, counter 0, dout = 0, out_valid = 0, cfg_ready = 0, cfg_done = 0. Partial loads are discarded.

## Timing
- Evaluation latency is 1 cycle, from in_valid sampled to out_valid/dout. Throughput is 1 per cycle, with no backpressure.
- A full load takes 1 (start) + TBL accepted bits + 1 (COMMIT) cycles minimum. cfg_valid may gap arbitrarily between bits.
- The table swap is atomic at the COMMIT edge:
  - in_valid in the COMMIT cycle evaluates against the old table;
  - in_valid in the cycle after evaluates against the new table.
- cfg_ready and cfg_done are registered (Moore) outputs decoded from state.

## Configuration
- Macro LUT_READBACK_EN.
- **Defined:** adds output port cfg_dout (1 bit) = shd[0], valid whenever cfg_ready is high. Because shd is preloaded from tbl on start, the previous table streams out, LSB-first, as the new one streams in. cfg_dout is 0 outside LOAD and under reset.
- **Undefined:** no cfg_dout port and no readback logic. Everything else is identical.

## Structure
- **Package lut_pkg:**
  - state enum {IDLE, LOAD, COMMIT};
  - function tbl_bits(K, N) = N << K;
  - constant DEFAULT_INIT3 = 8'h45.
- **Sub-module lut_cell #(K):**
  - one channel: 2^K-bit table slice plus K-bit address in, 1-bit combinational out;
  - instantiated N times via generate.
- The top level owns the FSM, counter, shd/tbl registers and output registers.

## Test plan
- **Reset default:** K=3, N=1, apply reset; sweep din 0..7 with in_valid. One cycle later dout = 1,0,1,0,0,0,1,0 (8'h45).
- **Reload:** cfg_start, then shift 8'h96 LSB-first. Expect cfg_ready high for 8 accepted bits, then cfg_done after 1 cycle. The din sweep then gives XOR3 (0,1,1,0,1,0,0,1).
- **Gapped load and atomic swap:** insert cfg_valid gaps and run in_valid continuously. dout follows 8'h45 through the COMMIT cycle and switches to the new table exactly one evaluation later.
- **Abort and reset mid-load:** after 4 bits, assert cfg_start; the next 8 bits fully define the table. In a second run, pulse rst_n after 5 bits: state IDLE, table back to 8'h45, dout = 0, out_valid = 0.
- **Multi-channel:** N=2, K=2, load 8'hE8 (channel 0 = AND 4'h8, channel 1 = OR 4'hE). din = 4'b01_11 gives dout = 2'b11; din = 4'b00_10 gives dout = 2'b00.
- **LUT_READBACK_EN:** with the macro defined, load 8'h96 after reset. cfg_dout must emit 1,0,1,0,0,0,1,0 (old 8'h45, LSB-first) on the 8 accepted cycles.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types and constants for the configurable LUT array.
// The FSM state type, the table-size helper and the reset table pattern
// are kept here so the top level and the bench agree on them.
package lut_pkg;

    // Configuration FSM: idle, shifting a new table in, swapping it live.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_e;

    // Reset function of a 3-input cell: F = !C && (!A || B), address {A,B,C}.
    localparam logic [7:0] DEFAULT_INIT3 = 8'h45;

    // Largest table supported: 64 channels of 6-input cells.
    localparam int MAX_TBL = 4096;

    // Default pattern repeated across the widest table; each instance takes
    // the low N*2^K bits, which for K=3 is exactly {N{8'h45}}.
    localparam logic [MAX_TBL-1:0] DEFAULT_FILL = {(MAX_TBL/8){DEFAULT_INIT3}};

    // Total table bits for N channels of K inputs.
    function automatic int tbl_bits(input int k, input int n);
        return n << k;
    endfunction

endpackage

// File: rtl/lut_cfg_array_if.sv
// Evaluation and serial-configuration bus of lut_cfg_array.
// Optional macro: LUT_READBACK_EN adds cfg_dout (previous table read out).
//
// Handshake rules: evaluation has no backpressure -- in_valid is sampled
// every cycle and produces out_valid/dout one cycle later. Configuration
// bits transfer on a cycle where cfg_valid && cfg_ready are both high;
// cfg_ready is a registered status that is high only while loading, and
// cfg_valid may drop for any number of cycles between bits.
interface lut_cfg_array_if #(
    parameter int K = 3,
    parameter int N = 1
);
    logic           in_valid;
    logic [N*K-1:0] din;
    logic           out_valid;
    logic [N-1:0]   dout;
    logic           cfg_start;
    logic           cfg_valid;
    logic           cfg_bit;
    logic           cfg_ready;
    logic           cfg_done;

`ifdef LUT_READBACK_EN
    logic           cfg_dout;

    modport master (
        output in_valid, din, cfg_start, cfg_valid, cfg_bit,
        input  out_valid, dout, cfg_ready, cfg_done, cfg_dout
    );
    modport slave (
        input  in_valid, din, cfg_start, cfg_valid, cfg_bit,
        output out_valid, dout, cfg_ready, cfg_done, cfg_dout
    );
`else
    modport master (
        output in_valid, din, cfg_start, cfg_valid, cfg_bit,
        input  out_valid, dout, cfg_ready, cfg_done
    );
    modport slave (
        input  in_valid, din, cfg_start, cfg_valid, cfg_bit,
        output out_valid, dout, cfg_ready, cfg_done
    );
`endif

endinterface

// File: rtl/lut_cell.sv
// One LUT channel: selects a single bit of its 2^K-entry table slice.
// Purely combinational; the parent registers the result.
module lut_cell #(
    parameter int K = 3
) (
    input  logic [(1<<K)-1:0] tbl,
    input  logic [K-1:0]      addr,
    output logic              y
);

    assign y = tbl[addr];

endmodule

// File: rtl/lut_cfg_array.sv
// Array of N reprogrammable K-input LUTs with registered outputs.
// A shadow table is shifted in serially (LSB-first) while evaluation keeps
// using the active table; the swap happens atomically at the COMMIT edge.
// Optional macro: LUT_READBACK_EN streams the previous table out on cfg_dout.
module lut_cfg_array
    import lut_pkg::*;
#(
    parameter int K = 3,
    parameter int N = 1,
    parameter logic [tbl_bits(K, N)-1:0] INIT = DEFAULT_FILL[tbl_bits(K, N)-1:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    lut_cfg_array_if.slave   bus,
    output lut_state_e       state_dbg
);

    localparam int TBL  = tbl_bits(K, N);
    localparam int CELL = 1 << K;
    localparam int CW   = $clog2(TBL);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBL - 1);

    lut_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TBL-1:0]  shd_q, shd_d;
    logic [TBL-1:0]  tbl_q, tbl_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            out_valid_q, out_valid_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            cfg_done_q, cfg_done_d;
    logic [N-1:0]    lut_y;

    // One combinational lookup per channel against the active table.
    for (genvar c = 0; c < N; c++) begin : g_cell
        lut_cell #(.K(K)) u_cell (
            .tbl  (tbl_q[c*CELL +: CELL]),
            .addr (bus.din[c*K +: K]),
            .y    (lut_y[c])
        );
    end

    // Configuration FSM: shadow preload, serial shift, atomic table swap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        tbl_d   = tbl_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    shd_d   = tbl_q;
                end
            end
            LOAD: begin
                if (bus.cfg_start) begin
                    // Restart: drop the partial load, no bit taken this cycle.
                    cnt_d = '0;
                    shd_d = tbl_q;
                end else if (bus.cfg_valid && cfg_ready_q) begin
                    shd_d = {bus.cfg_bit, shd_q[TBL-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            COMMIT: begin
                tbl_d   = shd_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cfg_ready_d = (state_d == LOAD);
        cfg_done_d  = (state_d == COMMIT);
    end

    // Evaluation: capture a fresh result when in_valid, otherwise hold dout.
    always_comb begin
        out_valid_d = bus.in_valid;
        dout_d      = bus.in_valid ? lut_y : dout_q;
    end

    // State and data registers; reset restores the default table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shd_q       <= INIT;
            tbl_q       <= INIT;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shd_q       <= shd_d;
            tbl_q       <= tbl_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cfg_ready = cfg_ready_q;
    assign bus.cfg_done  = cfg_done_q;
    assign state_dbg     = state_q;

`ifdef LUT_READBACK_EN
    // Shadow LSB is the next old-table bit to leave as a new one enters.
    assign bus.cfg_dout = cfg_ready_q & shd_q[0];
`else
`endif

endmodule
